// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: ALU codes, alu_op classes,
// funct7 patterns, FSM states and the multi-cycle classification helper.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SLL     = 4'b0011;
    localparam logic [3:0] ALU_SRL     = 4'b0100;
    localparam logic [3:0] ALU_SRA     = 4'b0101;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_SLTU    = 4'b1000;
    localparam logic [3:0] ALU_MUL     = 4'b1001;
    localparam logic [3:0] ALU_DIV     = 4'b1010;
    localparam logic [3:0] ALU_DIVU    = 4'b1011;
    localparam logic [3:0] ALU_XOR     = 4'b1100;
    localparam logic [3:0] ALU_REM     = 4'b1101;
    localparam logic [3:0] ALU_REMU    = 4'b1110;
    localparam logic [3:0] ALU_INVALID = 4'b1111;

    localparam logic [1:0] OP_MEM    = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_RTYPE  = 2'b10;
    localparam logic [1:0] OP_ITYPE  = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_OUT  = 2'b10
    } state_t;

    function automatic logic is_multi(input logic [3:0] code);
        return code inside {ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of alu_op/funct3/funct7 into a 4-bit ALU control code,
// with RV32M support selectable by EN_M.
module alu_decode
    import alu_ctrl_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] code,
    output logic       multi_cycle,
    output logic       illegal
);

    always_comb begin
        code = ALU_INVALID;
        case (alu_op)
            OP_MEM:    code = ALU_ADD;
            OP_BRANCH: code = ALU_SUB;
            OP_RTYPE: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  code = ALU_ADD;
                        3'b001:  code = ALU_SLL;
                        3'b010:  code = ALU_SLT;
                        3'b011:  code = ALU_SLTU;
                        3'b100:  code = ALU_XOR;
                        3'b101:  code = ALU_SRL;
                        3'b110:  code = ALU_OR;
                        default: code = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000)      code = ALU_SUB;
                    else if (funct3 == 3'b101) code = ALU_SRA;
                end else if (EN_M && funct7 == F7_MULDIV) begin
                    // MULH/MULHSU/MULHU are not supported by the MDU behind us.
                    case (funct3)
                        3'b000:  code = ALU_MUL;
                        3'b100:  code = ALU_DIV;
                        3'b101:  code = ALU_DIVU;
                        3'b110:  code = ALU_REM;
                        3'b111:  code = ALU_REMU;
                        default: code = ALU_INVALID;
                    endcase
                end
            end
            default: begin
                case (funct3)
                    3'b000:  code = ALU_ADD;
                    3'b010:  code = ALU_SLT;
                    3'b011:  code = ALU_SLTU;
                    3'b100:  code = ALU_XOR;
                    3'b110:  code = ALU_OR;
                    3'b111:  code = ALU_AND;
                    3'b001:  if (funct7 == F7_BASE) code = ALU_SLL;
                    default: begin
                        if (funct7 == F7_BASE)     code = ALU_SRL;
                        else if (funct7 == F7_ALT) code = ALU_SRA;
                    end
                endcase
            end
        endcase
        illegal     = (code == ALU_INVALID);
        multi_cycle = is_multi(code);
    end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control sequencer: registers the decoded code on a valid/ready accept and
// holds it through a latency countdown for multi-cycle MUL/DIV operations.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter bit EN_M    = 1'b1,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] alu_ctrl,
    output logic       multi_cycle,
    output logic       illegal,
    output logic       busy
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam bit               MUL_ONE  = (MUL_LAT == 1);
    localparam bit               DIV_ONE  = (DIV_LAT == 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       dec_code;
    logic             dec_multi, dec_illegal;
    logic             accept;
    logic             dec_is_mul;

    alu_decode #(.EN_M(EN_M)) u_decode (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7      (funct7),
        .code        (dec_code),
        .multi_cycle (dec_multi),
        .illegal     (dec_illegal)
    );

    assign in_ready   = !rst && ((state == ST_IDLE) || (state == ST_OUT && out_ready));
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state == ST_OUT);
    assign busy       = (state == ST_WAIT);
    assign dec_is_mul = (dec_code == ALU_MUL);

    // An accepted multi-cycle op with latency above one counts down in WAIT;
    // everything else lands directly in OUT on the next cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE, ST_OUT: begin
                if (accept) begin
                    if (dec_multi && !(dec_is_mul ? MUL_ONE : DIV_ONE)) begin
                        state_next = ST_WAIT;
                        cnt_next   = dec_is_mul ? MUL_LOAD : DIV_LOAD;
                    end else begin
                        state_next = ST_OUT;
                    end
                end else if (state == ST_OUT && out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_next = ST_OUT;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            alu_ctrl    <= ALU_INVALID;
            multi_cycle <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                alu_ctrl    <= dec_code;
                multi_cycle <= dec_multi;
                illegal     <= dec_illegal;
            end
        end
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: two parameterisations, directed
// scenarios plus randomized traffic compared against a transaction-level model.
module tb_alu_control_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst       [2];
    logic       in_valid  [2];
    logic       out_ready [2];
    logic [1:0] alu_op    [2];
    logic [2:0] funct3    [2];
    logic [6:0] funct7    [2];
    logic       in_ready    [2];
    logic       out_valid   [2];
    logic       multi_cycle [2];
    logic       illegal     [2];
    logic       busy        [2];
    logic [3:0] alu_ctrl    [2];

    int mul_lat [2] = '{16, 3};
    int div_lat [2] = '{32, 5};
    bit en_m    [2] = '{1'b1, 1'b0};

    alu_control_seq #(.MUL_LAT(16), .DIV_LAT(32), .EN_M(1'b1), .CNT_W(6)) dut_m (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .alu_op(alu_op[0]), .funct3(funct3[0]), .funct7(funct7[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .alu_ctrl(alu_ctrl[0]),
        .multi_cycle(multi_cycle[0]), .illegal(illegal[0]), .busy(busy[0])
    );

    alu_control_seq #(.MUL_LAT(3), .DIV_LAT(5), .EN_M(1'b0), .CNT_W(3)) dut_nom (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .alu_op(alu_op[1]), .funct3(funct3[1]), .funct7(funct7[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .alu_ctrl(alu_ctrl[1]),
        .multi_cycle(multi_cycle[1]), .illegal(illegal[1]), .busy(busy[1])
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Model: one in-flight op per instance with cycles remaining until valid.
    bit         m_init [2];
    bit         m_have [2];
    int         m_rem  [2];
    logic [3:0] m_code [2];
    bit         m_multi[2];
    bit         m_ill  [2];

    logic       s_ready [2];
    logic       s_valid [2];
    logic       s_busy  [2];
    logic       s_multi [2];
    logic       s_ill   [2];
    logic [3:0] s_ctrl  [2];

    function automatic logic [3:0] refDecode(input logic [1:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7, input bit m_on);
        logic [3:0] r;
        r = 4'hF;
        if (op == 2'b00) r = 4'h2;
        else if (op == 2'b01) r = 4'h6;
        else if (op == 2'b10) begin
            if (f7 == 7'h00) begin
                case (f3)
                    3'd0: r = 4'h2;  3'd1: r = 4'h3;  3'd2: r = 4'h7;  3'd3: r = 4'h8;
                    3'd4: r = 4'hC;  3'd5: r = 4'h4;  3'd6: r = 4'h1;  default: r = 4'h0;
                endcase
            end else if (f7 == 7'h20) begin
                if (f3 == 3'd0) r = 4'h6;
                if (f3 == 3'd5) r = 4'h5;
            end else if (f7 == 7'h01 && m_on) begin
                case (f3)
                    3'd0: r = 4'h9;  3'd4: r = 4'hA;  3'd5: r = 4'hB;
                    3'd6: r = 4'hD;  3'd7: r = 4'hE;  default: r = 4'hF;
                endcase
            end
        end else begin
            case (f3)
                3'd0: r = 4'h2;  3'd2: r = 4'h7;  3'd3: r = 4'h8;
                3'd4: r = 4'hC;  3'd6: r = 4'h1;  3'd7: r = 4'h0;
                3'd1: r = (f7 == 7'h00) ? 4'h3 : 4'hF;
                default: r = (f7 == 7'h00) ? 4'h4 : ((f7 == 7'h20) ? 4'h5 : 4'hF);
            endcase
        end
        return r;
    endfunction

    function automatic bit refMulti(input logic [3:0] code);
        return (code == 4'h9) || (code == 4'hA) || (code == 4'hB) || (code == 4'hD) || (code == 4'hE);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive one cycle, compare outputs against the model before the edge, then advance.
    task automatic applyStimulus(input int sel, input logic r, input logic iv,
                                 input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic ordy, output bit acc);
        bit e_valid, e_busy, e_ready;
        int lat;
        rst[sel] = r; in_valid[sel] = iv; alu_op[sel] = op;
        funct3[sel] = f3; funct7[sel] = f7; out_ready[sel] = ordy;
        #1;
        s_ready[sel] = in_ready[sel];  s_valid[sel] = out_valid[sel];
        s_busy[sel]  = busy[sel];      s_multi[sel] = multi_cycle[sel];
        s_ill[sel]   = illegal[sel];   s_ctrl[sel]  = alu_ctrl[sel];
        acc = 1'b0;
        if (m_init[sel]) begin
            e_valid = m_have[sel] && (m_rem[sel] == 0);
            e_busy  = m_have[sel] && (m_rem[sel] > 0);
            e_ready = !r && (!m_have[sel] || (e_valid && ordy));
            acc     = e_ready && iv;
            checkOutput($sformatf("i%0d in_ready", sel), 32'(s_ready[sel]), 32'(e_ready));
            checkOutput($sformatf("i%0d out_valid", sel), 32'(s_valid[sel]), 32'(e_valid));
            checkOutput($sformatf("i%0d busy", sel), 32'(s_busy[sel]), 32'(e_busy));
            checkOutput($sformatf("i%0d alu_ctrl", sel), 32'(s_ctrl[sel]), 32'(m_code[sel]));
            checkOutput($sformatf("i%0d multi_cycle", sel), 32'(s_multi[sel]), 32'(m_multi[sel]));
            checkOutput($sformatf("i%0d illegal", sel), 32'(s_ill[sel]), 32'(m_ill[sel]));
        end
        @(posedge clk);
        if (r) begin
            m_init[sel] = 1'b1; m_have[sel] = 1'b0; m_rem[sel] = 0;
            m_code[sel] = 4'hF; m_multi[sel] = 1'b0; m_ill[sel] = 1'b0;
        end else if (acc) begin
            m_code[sel]  = refDecode(op, f3, f7, en_m[sel]);
            m_multi[sel] = refMulti(m_code[sel]);
            m_ill[sel]   = (m_code[sel] == 4'hF);
            lat = !m_multi[sel] ? 1 : ((m_code[sel] == 4'h9) ? mul_lat[sel] : div_lat[sel]);
            m_have[sel] = 1'b1;
            m_rem[sel]  = lat - 1;
        end else if (m_have[sel] && m_rem[sel] == 0 && ordy) begin
            m_have[sel] = 1'b0;
        end else if (m_have[sel] && m_rem[sel] > 0) begin
            m_rem[sel]--;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idleCycles(input int sel, input int n);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(sel, 1'b0, 1'b0, 2'b00, 3'b000, 7'h00, 1'b1, acc);
    endtask

    task automatic runRandom(input int sel, input int n);
        bit         acc, pv;
        logic [1:0] pop;
        logic [2:0] pf3;
        logic [6:0] pf7;
        logic       r, ordy;
        pv = 1'b0; pop = '0; pf3 = '0; pf7 = '0;
        for (int i = 0; i < n; i++) begin
            if (!pv && $urandom_range(0, 9) < 7) begin
                pv  = 1'b1;
                pop = 2'($urandom);
                pf3 = 3'($urandom);
                case ($urandom_range(0, 3))
                    0: pf7 = 7'h00;
                    1: pf7 = 7'h20;
                    2: pf7 = 7'h01;
                    default: pf7 = 7'($urandom);
                endcase
            end
            r    = ($urandom_range(0, 199) == 0);
            ordy = ($urandom_range(0, 9) < 7);
            applyStimulus(sel, r, pv, pop, pf3, pf7, ordy, acc);
            if (acc) pv = 1'b0;
        end
    endtask

    initial begin
        bit   acc;
        int   busy_cnt, lat, early, bad, stale;
        logic [3:0] v_ctrl;
        logic v_multi, v_ready;

        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; in_valid[s] = 1'b0; out_ready[s] = 1'b0;
            alu_op[s] = '0; funct3[s] = '0; funct7[s] = '0;
            m_init[s] = 1'b0; m_have[s] = 1'b0; m_rem[s] = 0;
            m_code[s] = 4'hF; m_multi[s] = 1'b0; m_ill[s] = 1'b0;
        end
        @(negedge clk);

        $display("[TB] reset release");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 1'b0, 2'b00, 3'b000, 7'h00, 1'b1, acc);
        applyStimulus(0, 1'b0, 1'b0, 2'b00, 3'b000, 7'h00, 1'b1, acc);
        checkOutput("rst_ctrl",  32'(s_ctrl[0]),  32'hF);
        checkOutput("rst_valid", 32'(s_valid[0]), 32'h0);
        checkOutput("rst_multi", 32'(s_multi[0]), 32'h0);
        checkOutput("rst_ill",   32'(s_ill[0]),   32'h0);
        checkOutput("rst_busy",  32'(s_busy[0]),  32'h0);
        checkOutput("rst_ready", 32'(s_ready[0]), 32'h1);

        $display("[TB] back-to-back single-cycle");
        applyStimulus(0, 1'b0, 1'b1, 2'b10, 3'b000, 7'h20, 1'b1, acc);
        checkOutput("b2b_ready0", 32'(s_ready[0]), 32'h1);
        applyStimulus(0, 1'b0, 1'b1, 2'b11, 3'b101, 7'h20, 1'b1, acc);
        checkOutput("b2b_sub",    32'(s_ctrl[0]),  32'h6);
        checkOutput("b2b_valid1", 32'(s_valid[0]), 32'h1);
        checkOutput("b2b_ready1", 32'(s_ready[0]), 32'h1);
        applyStimulus(0, 1'b0, 1'b0, 2'b00, 3'b000, 7'h00, 1'b1, acc);
        checkOutput("b2b_sra",    32'(s_ctrl[0]),  32'h5);
        checkOutput("b2b_valid2", 32'(s_valid[0]), 32'h1);
        idleCycles(0, 1);

        $display("[TB] DIV latency with held request");
        applyStimulus(0, 1'b0, 1'b1, 2'b10, 3'b100, 7'h01, 1'b1, acc);
        busy_cnt = 0; lat = 0; early = 0; v_ctrl = '0; v_multi = 1'b0; v_ready = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            applyStimulus(0, 1'b0, 1'b1, 2'b00, 3'b000, 7'h00, 1'b1, acc);
            if (s_busy[0] === 1'b1) busy_cnt++;
            if (s_valid[0] === 1'b1) begin
                lat = k; v_ctrl = s_ctrl[0]; v_multi = s_multi[0]; v_ready = s_ready[0];
                break;
            end else if (s_ready[0] !== 1'b0) begin
                early++;
            end
        end
        checkOutput("div_busy_cycles", 32'(busy_cnt), 32'd31);
        checkOutput("div_latency",     32'(lat),      32'd32);
        checkOutput("div_ctrl",        32'(v_ctrl),   32'hA);
        checkOutput("div_multi",       32'(v_multi),  32'h1);
        checkOutput("div_ready_out",   32'(v_ready),  32'h1);
        checkOutput("div_early_ready", 32'(early),    32'd0);
        idleCycles(0, 2);

        $display("[TB] backpressure");
        applyStimulus(0, 1'b0, 1'b1, 2'b00, 3'b111, 7'h7F, 1'b1, acc);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1'b0, 1'b1, 2'b01, 3'b000, 7'h00, 1'b0, acc);
            if (s_valid[0] !== 1'b1 || s_ctrl[0] !== 4'h2 || s_ready[0] !== 1'b0 ||
                s_ill[0] !== 1'b0 || s_multi[0] !== 1'b0) bad++;
        end
        checkOutput("bp_hold_cycles", 32'(bad), 32'd0);
        applyStimulus(0, 1'b0, 1'b1, 2'b01, 3'b000, 7'h00, 1'b1, acc);
        checkOutput("bp_release_ready", 32'(s_ready[0]), 32'h1);
        applyStimulus(0, 1'b0, 1'b0, 2'b00, 3'b000, 7'h00, 1'b1, acc);
        checkOutput("bp_next_sub", 32'(s_ctrl[0]), 32'h6);
        idleCycles(0, 1);

        $display("[TB] illegal encodings");
        applyStimulus(0, 1'b0, 1'b1, 2'b10, 3'b100, 7'h20, 1'b1, acc);
        applyStimulus(0, 1'b0, 1'b1, 2'b11, 3'b001, 7'h20, 1'b1, acc);
        checkOutput("ill_r_ctrl", 32'(s_ctrl[0]), 32'hF);
        checkOutput("ill_r_flag", 32'(s_ill[0]),  32'h1);
        applyStimulus(0, 1'b0, 1'b0, 2'b00, 3'b000, 7'h00, 1'b1, acc);
        checkOutput("ill_i_ctrl", 32'(s_ctrl[0]), 32'hF);
        checkOutput("ill_i_flag", 32'(s_ill[0]),  32'h1);
        idleCycles(0, 1);

        $display("[TB] reset during MUL");
        applyStimulus(0, 1'b0, 1'b1, 2'b10, 3'b000, 7'h01, 1'b1, acc);
        idleCycles(0, 9);
        checkOutput("mr_busy_before", 32'(s_busy[0]), 32'h1);
        applyStimulus(0, 1'b1, 1'b0, 2'b00, 3'b000, 7'h00, 1'b1, acc);
        applyStimulus(0, 1'b0, 1'b0, 2'b00, 3'b000, 7'h00, 1'b1, acc);
        checkOutput("mr_valid", 32'(s_valid[0]), 32'h0);
        checkOutput("mr_busy",  32'(s_busy[0]),  32'h0);
        checkOutput("mr_ready", 32'(s_ready[0]), 32'h1);
        checkOutput("mr_ctrl",  32'(s_ctrl[0]),  32'hF);
        stale = 0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(0, 1'b0, 1'b0, 2'b00, 3'b000, 7'h00, 1'b1, acc);
            if (s_valid[0] !== 1'b0) stale++;
        end
        checkOutput("mr_stale", 32'(stale), 32'd0);

        $display("[TB] random traffic, M enabled");
        runRandom(0, 1500);

        $display("[TB] M disabled");
        for (int i = 0; i < 2; i++) applyStimulus(1, 1'b1, 1'b0, 2'b00, 3'b000, 7'h00, 1'b1, acc);
        applyStimulus(1, 1'b0, 1'b1, 2'b10, 3'b000, 7'h01, 1'b1, acc);
        applyStimulus(1, 1'b0, 1'b0, 2'b00, 3'b000, 7'h00, 1'b1, acc);
        checkOutput("nom_ctrl",  32'(s_ctrl[1]),  32'hF);
        checkOutput("nom_ill",   32'(s_ill[1]),   32'h1);
        checkOutput("nom_valid", 32'(s_valid[1]), 32'h1);
        checkOutput("nom_multi", 32'(s_multi[1]), 32'h0);
        checkOutput("nom_busy",  32'(s_busy[1]),  32'h0);

        $display("[TB] random traffic, M disabled");
        runRandom(1, 1500);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        n_errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Parametrised next-generation ALU control: decodes `alu_op`/`funct3`/`funct7` into a 4-bit ALU control code covering full RV32I plus optional RV32M multiply/divide. A valid/ready handshake sits on both sides, and an FSM with a latency counter holds the code stable for multi-cycle MUL/DIV ops. It sits between the control unit/decode stage and the ALU/MDU in the execute stage.

## Interface
- `MUL_LAT`, default 4: cycles from accept to `out_valid` for MUL; must be ≥1.
- `DIV_LAT`, default 32: cycles from accept to `out_valid` for DIV/DIVU/REM/REMU; must be ≥1.
- `EN_M`, default 1: when 1, M-extension ops are decoded; when 0, they decode as illegal.
- `CNT_W`, default 6: latency counter width; must be ≥ clog2(max(MUL_LAT,DIV_LAT)+1).
- `clk` in 1: the only clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: decode request is present.
- `in_ready` out 1: block can accept a request this cycle.
- `alu_op` in 2: 00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- `funct3` in 3: instruction bits [14:12].
- `funct7` in 7: instruction bits [31:25].
- `out_valid` out 1: `alu_ctrl` is valid.
- `out_ready` in 1: consumer takes the output this cycle.
- `alu_ctrl` out 4: registered ALU control code.
- `multi_cycle` out 1: the current output is an M-extension op.
- `illegal` out 1: the current output is an undefined encoding (`alu_ctrl`=1111).
- `busy` out 1: a multi-cycle latency count is in progress.

## Operation
- **Codes:** AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SRA 0101, SUB 0110, SLT 0111, SLTU 1000, MUL 1001, DIV 1010, DIVU 1011, XOR 1100, REM 1101, REMU 1110, invalid 1111.
- **alu_op 00:** ADD. **alu_op 01:** SUB. `funct3`/`funct7` are ignored for both.
- **alu_op 10, funct7 0000000:** funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- **alu_op 10, funct7 0100000:** funct3 000 SUB, 101 SRA; all other funct3 are illegal.
- **alu_op 10, funct7 0000001, EN_M=1:** funct3 000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU; funct3 001/010/011 (MULH*) are illegal.
- **alu_op 10, any other funct7:** illegal.
- **alu_op 11:** funct3 000/010/011/100/110/111 map to ADD/SLT/SLTU/XOR/OR/AND with `funct7` ignored. funct3 001 is SLL only when funct7=0000000. funct3 101 is SRL for funct7=0000000 and SRA for 0100000. Everything else is illegal. M ops never decode here.
- **Illegal requests:** output 1111 with `illegal`=1, treated as single-cycle.
- **FSM states:**
  - IDLE: no output; `in_ready`=1.
  - WAIT: counting; `busy`=1, `in_ready`=0.
  - OUT: `out_valid`=1.
- **Accept** = `in_valid` & `in_ready`. The decoded code, `multi_cycle` and `illegal` are registered on accept.
- **Transitions:**
  - Single-cycle accept goes to OUT.
  - Multi-cycle accept with L>1 goes to WAIT with the counter loaded to L-1; L=1 goes straight to OUT.
  - WAIT decrements the counter each cycle and moves to OUT on the cycle after the count reaches 1.
  - OUT with `out_ready`=1 and no new accept goes to IDLE.
  - OUT with `out_ready`=1 and a new accept loads the new op, so single-cycle ops issue back-to-back.
- **`in_ready`** = (state==IDLE) | (state==OUT & `out_ready`), forced 0 while `rst`=1.

## Timing
- **Reset values:** `out_valid` 0, `alu_ctrl` 1111, `multi_cycle` 0, `illegal` 0, `busy` 0, state IDLE, counter 0.
- **Reset mid-operation:** any in-flight WAIT or OUT is discarded and the block is in IDLE the cycle after `rst` is sampled high. No output is produced for the discarded op.
- **Latency:** accept at cycle T gives `out_valid` at T+1 for single-cycle/illegal ops, T+`MUL_LAT` for MUL, T+`DIV_LAT` for DIV/DIVU/REM/REMU.
- **Throughput:** one single-cycle op per cycle while `out_ready`=1.
- **Hold rules:**
  - `alu_ctrl`, `multi_cycle` and `illegal` are stable from the cycle after accept through WAIT and OUT until the output is taken.
  - While `out_valid`=1 and `out_ready`=0, every output holds and `in_ready`=0.
- `busy` is high exactly during WAIT cycles, which is L-1 cycles per multi-cycle op.
- `in_valid` with `in_ready`=0 is not accepted; the producer must hold the request.

## Structure
- **Package `alu_ctrl_pkg`:** 4-bit code localparams (including `ALU_INVALID`=1111), `alu_op` encodings, `funct7` constants (0000000, 0100000, 0000001), and an `is_multi` helper.
- **Sub-module `alu_decode`:** purely combinational; takes (`alu_op`, `funct3`, `funct7`) and `EN_M`, returns (code, `multi_cycle`, `illegal`).
- **`alu_control_seq`:** holds the FSM, the `CNT_W` counter and the output registers.

## Test plan
- **Reset release:** reset then idle → all outputs at reset values, `in_ready`=1 the cycle after `rst` falls.
- **Back-to-back single-cycle:** alu_op=10 with funct3=000, funct7=0100000, then alu_op=11 with funct3=101, funct7=0100000, `out_ready`=1 → `alu_ctrl` 0110 at T+1, then 0101 at T+2, `in_ready` held 1.
- **DIV latency and stall:** DIV (alu_op=10, funct7=0000001, funct3=100) with DIV_LAT=32 → `busy` high for 31 cycles, `alu_ctrl`=1010 and `multi_cycle`=1, `out_valid` at T+32; `in_valid` is held high throughout and is not accepted until OUT & `out_ready`.
- **M disabled:** EN_M=0, MUL request → `alu_ctrl`=1111, `illegal`=1 at T+1, `busy` never asserts.
- **Illegal encodings:** alu_op=10, funct7=0100000, funct3=100, and alu_op=11, funct3=001, funct7=0100000 → 1111 with `illegal`=1.
- **Backpressure and mid-op reset:**
  - Backpressure: `out_ready`=0 for 5 cycles on an ADD output → output stable and `in_ready`=0 for those cycles.
  - Mid-op reset: `rst` pulsed in cycle 10 of a MUL_LAT=16 op → state IDLE, `out_valid`=0 next cycle, no stale output afterwards.
